jb_pa_slew_prot_ctrl: RTL and testbench

Protection controller that sequences the IQ slew-error detector in the PA protection path. It supplies the detector's slew threshold and aligns sample-valid with the detector's pipeline latency. It counts slew errors over a programmable sample window and drives the PA blanking request through an armed/tripped/hold-off state machine with software clear or automatic re-arm.

---
 rtl/jb_pa_prot_pkg.sv | 16 +
 rtl/jb_valid_delay_line.sv | 30 +++
 rtl/jb_pa_slew_prot_ctrl.sv | 147 ++++++++++++++
 tb/tb_jb_pa_slew_prot_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_pa_prot_pkg.sv
// Shared types and constants for the PA slew-protection controller.
package jb_pa_prot_pkg;

    localparam int unsigned SLEW_THR_W = 33;

    // All-ones threshold keeps the detector from ever flagging an error.
    localparam logic [SLEW_THR_W-1:0] SLEW_THR_RESET = 33'h1_FFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StTripped = 2'd2,
        StHoldoff = 2'd3
    } prot_state_t;

endpackage

// File: rtl/jb_valid_delay_line.sv
// Fixed-depth shift register that aligns a valid strobe with a pipelined result.
module jb_valid_delay_line #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/jb_pa_slew_prot_ctrl.sv
// Slew-error protection sequencer: windowed error counting, trip/hold-off FSM
// and PA blanking request, with the detector threshold shadowed on safe boundaries.
module jb_pa_slew_prot_ctrl
    import jb_pa_prot_pkg::*;
#(
    parameter int unsigned DET_LATENCY = 4,
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned TRIP_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_enable,
    input  logic                  cfg_auto_rearm,
    input  logic                  cfg_clear,
    input  logic [SLEW_THR_W-1:0] cfg_slew_threshold,
    input  logic [ERR_CNT_W-1:0]  cfg_err_limit,
    input  logic [WIN_W-1:0]      cfg_window_len,
    input  logic [WIN_W-1:0]      cfg_holdoff_len,
    input  logic                  iq_valid,
    input  logic                  iq_slew_error,
    output logic [SLEW_THR_W-1:0] slew_threshold,
    output logic                  pa_blank,
    output logic                  trip_pulse,
    output logic [1:0]            prot_state,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [TRIP_CNT_W-1:0] trip_count
);

    prot_state_t           state_q;
    logic [SLEW_THR_W-1:0] thr_q;
    logic                  pa_blank_q;
    logic                  trip_pulse_q;
    logic [WIN_W-1:0]      win_q;
    logic [ERR_CNT_W-1:0]  err_q;
    logic [WIN_W-1:0]      hold_q;
    logic [TRIP_CNT_W-1:0] trip_q;

    logic                  det_valid;
    logic [ERR_CNT_W-1:0]  err_lim;
    logic [ERR_CNT_W-1:0]  err_inc;
    logic [WIN_W-1:0]      win_inc;
    logic [WIN_W-1:0]      hold_load;
    logic [TRIP_CNT_W-1:0] trip_inc;
    logic                  win_done;
    logic                  trip_hit;

    jb_valid_delay_line #(
        .DEPTH (DET_LATENCY)
    ) u_valid_dly (
        .clk    (clk),
        .resetn (resetn),
        .din    (iq_valid),
        .dout   (det_valid)
    );

    assign err_lim   = (cfg_err_limit == '0) ? ERR_CNT_W'(1) : cfg_err_limit;
    assign err_inc   = (iq_slew_error && (err_q != '1)) ? err_q + 1'b1 : err_q;
    assign win_inc   = win_q + 1'b1;
    assign win_done  = (cfg_window_len != '0) && (win_inc == cfg_window_len);
    assign trip_hit  = det_valid && (err_inc >= err_lim);
    assign hold_load = (cfg_holdoff_len == '0) ? WIN_W'(1) : cfg_holdoff_len;
    assign trip_inc  = (trip_q == '1) ? trip_q : trip_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            thr_q        <= SLEW_THR_RESET;
            pa_blank_q   <= 1'b0;
            trip_pulse_q <= 1'b0;
            win_q        <= '0;
            err_q        <= '0;
            hold_q       <= '0;
            trip_q       <= '0;
        end else begin
            trip_pulse_q <= 1'b0;
            if (cfg_clear) begin
                trip_q <= '0;
            end
            if (state_q == StIdle) begin
                thr_q <= cfg_slew_threshold;
            end

            if (!cfg_enable) begin
                state_q    <= StIdle;
                pa_blank_q <= 1'b0;
                win_q      <= '0;
                err_q      <= '0;
                hold_q     <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StArmed;
                        win_q   <= '0;
                        err_q   <= '0;
                    end
                    StArmed: begin
                        if (det_valid) begin
                            if (trip_hit) begin
                                // A coincident clear loses to the trip: count restarts at 1.
                                state_q      <= StTripped;
                                pa_blank_q   <= 1'b1;
                                trip_pulse_q <= 1'b1;
                                err_q        <= err_inc;
                                win_q        <= win_inc;
                                trip_q       <= cfg_clear ? TRIP_CNT_W'(1) : trip_inc;
                            end else if (win_done) begin
                                win_q <= '0;
                                err_q <= '0;
                                thr_q <= cfg_slew_threshold;
                            end else begin
                                win_q <= win_inc;
                                err_q <= err_inc;
                            end
                        end
                    end
                    StTripped: begin
                        if (cfg_auto_rearm || cfg_clear) begin
                            state_q <= StHoldoff;
                            hold_q  <= hold_load;
                        end
                    end
                    StHoldoff: begin
                        if (hold_q <= WIN_W'(1)) begin
                            state_q    <= StArmed;
                            pa_blank_q <= 1'b0;
                            win_q      <= '0;
                            err_q      <= '0;
                            hold_q     <= '0;
                            thr_q      <= cfg_slew_threshold;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign slew_threshold = thr_q;
    assign pa_blank       = pa_blank_q;
    assign trip_pulse     = trip_pulse_q;
    assign prot_state     = state_q;
    assign err_count      = err_q;
    assign trip_count     = trip_q;

endmodule

// File: tb/tb_jb_pa_slew_prot_ctrl.sv
// Directed bench for jb_pa_slew_prot_ctrl; errors are driven DET_LATENCY clocks after their sample.
module tb_jb_pa_slew_prot_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_enable;
    logic        cfg_auto_rearm;
    logic        cfg_clear;
    logic [32:0] cfg_slew_threshold;
    logic [7:0]  cfg_err_limit;
    logic [15:0] cfg_window_len;
    logic [15:0] cfg_holdoff_len;
    logic        iq_valid;
    logic        iq_slew_error;
    logic [32:0] slew_threshold;
    logic        pa_blank;
    logic        trip_pulse;
    logic [1:0]  prot_state;
    logic [7:0]  err_count;
    logic [15:0] trip_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [32:0] THR0 = 33'h0_0001_0000;
    localparam logic [32:0] THR1 = 33'h0_0002_0000;
    localparam logic [32:0] THR2 = 33'h1_2345_6789;

    jb_pa_slew_prot_ctrl #(
        .DET_LATENCY (4),
        .ERR_CNT_W   (8),
        .WIN_W       (16),
        .TRIP_CNT_W  (16)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cfg_enable         (cfg_enable),
        .cfg_auto_rearm     (cfg_auto_rearm),
        .cfg_clear          (cfg_clear),
        .cfg_slew_threshold (cfg_slew_threshold),
        .cfg_err_limit      (cfg_err_limit),
        .cfg_window_len     (cfg_window_len),
        .cfg_holdoff_len    (cfg_holdoff_len),
        .iq_valid           (iq_valid),
        .iq_slew_error      (iq_slew_error),
        .slew_threshold     (slew_threshold),
        .pa_blank           (pa_blank),
        .trip_pulse         (trip_pulse),
        .prot_state         (prot_state),
        .err_count          (err_count),
        .trip_count         (trip_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) step;
        n_tests++;
        if (slew_threshold !== 33'h1_FFFF_FFFF) begin
            n_fail++; $display("FAIL reset_thr got %h want 1ffffffff", slew_threshold);
        end
        n_tests++;
        if (prot_state !== 2'd0 || pa_blank !== 1'b0 || trip_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl got st=%0d blank=%b pulse=%b want 0/0/0",
                               prot_state, pa_blank, trip_pulse);
        end
        n_tests++;
        if (err_count !== 8'd0 || trip_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt got err=%0d trips=%0d want 0/0",
                               err_count, trip_count);
        end
        resetn = 1'b1;
        step;
        n_tests++;
        if (slew_threshold !== THR0 || prot_state !== 2'd0 || pa_blank !== 1'b0) begin
            n_fail++; $display("FAIL idle_track got thr=%h st=%0d blank=%b want %h/0/0",
                               slew_threshold, prot_state, pa_blank, THR0);
        end
    endtask

    // limit 3, window 8, errors on samples 2, 5, 7 (trip on the window's last sample)
    task automatic test_trip;
        cfg_err_limit  = 8'd3;
        cfg_window_len = 16'd8;
        cfg_enable     = 1'b1;
        step;
        n_tests++;
        if (prot_state !== 2'd1) begin
            n_fail++; $display("FAIL arm got st=%0d want 1", prot_state);
        end
        for (int c = 0; c < 12; c++) begin
            iq_valid      = (c < 8);
            iq_slew_error = (c == 6 || c == 9 || c == 11);
            step;
            if (c == 10) begin
                n_tests++;
                if (err_count !== 8'd2 || prot_state !== 2'd1 || pa_blank !== 1'b0) begin
                    n_fail++; $display("FAIL pre_trip got err=%0d st=%0d blank=%b want 2/1/0",
                                       err_count, prot_state, pa_blank);
                end
            end
        end
        n_tests++;
        if (prot_state !== 2'd2 || pa_blank !== 1'b1 || trip_pulse !== 1'b1) begin
            n_fail++; $display("FAIL trip got st=%0d blank=%b pulse=%b want 2/1/1",
                               prot_state, pa_blank, trip_pulse);
        end
        n_tests++;
        if (trip_count !== 16'd1 || err_count !== 8'd3) begin
            n_fail++; $display("FAIL trip_cnt got trips=%0d err=%0d want 1/3",
                               trip_count, err_count);
        end
        iq_valid      = 1'b0;
        iq_slew_error = 1'b0;
        step;
        n_tests++;
        if (trip_pulse !== 1'b0 || prot_state !== 2'd2) begin
            n_fail++; $display("FAIL pulse_width got pulse=%b st=%0d want 0/2",
                               trip_pulse, prot_state);
        end
    endtask

    task automatic test_manual_clear;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step;
            if (prot_state !== 2'd2 || pa_blank !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL tripped_hold got %0d bad cycles want 0", bad);
        end
        cfg_clear = 1'b1;
        step;
        cfg_clear = 1'b0;
        n_tests++;
        if (prot_state !== 2'd3 || trip_count !== 16'd0 || pa_blank !== 1'b1) begin
            n_fail++; $display("FAIL clear got st=%0d trips=%0d blank=%b want 3/0/1",
                               prot_state, trip_count, pa_blank);
        end
        repeat (4) step;
        n_tests++;
        if (prot_state !== 2'd3) begin
            n_fail++; $display("FAIL holdoff_len got st=%0d want 3", prot_state);
        end
        step;
        n_tests++;
        if (prot_state !== 2'd1 || pa_blank !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL rearm got st=%0d blank=%b err=%0d want 1/0/0",
                               prot_state, pa_blank, err_count);
        end
    endtask

    // limit 3, window 4, errors on window positions 0 and 2: never trips
    task automatic test_window_rollover;
        logic [32:0] exp_thr;
        exp_thr            = THR0;
        cfg_window_len     = 16'd4;
        cfg_slew_threshold = THR1;
        for (int c = 0; c < 16; c++) begin
            int j;
            j = c - 4;
            iq_valid      = (c < 12);
            iq_slew_error = (c >= 4) && (j < 12) && ((j % 4 == 0) || (j % 4 == 2));
            if (c == 9) cfg_slew_threshold = THR2;
            step;
            if (c >= 4 && j % 4 == 3) exp_thr = cfg_slew_threshold;
            n_tests++;
            if (prot_state !== 2'd1 || slew_threshold !== exp_thr) begin
                n_fail++; $display("FAIL win_c%0d got st=%0d thr=%h want 1/%h",
                                   c, prot_state, slew_threshold, exp_thr);
            end
            if (c >= 4 && j % 4 == 2) begin
                n_tests++;
                if (err_count !== 8'd2) begin
                    n_fail++; $display("FAIL win_err_c%0d got %0d want 2", c, err_count);
                end
            end
            if (c >= 4 && j % 4 == 3) begin
                n_tests++;
                if (err_count !== 8'd0) begin
                    n_fail++; $display("FAIL rollover_c%0d got %0d want 0", c, err_count);
                end
            end
        end
    endtask

    task automatic test_auto_rearm;
        int blank_cnt;
        cfg_auto_rearm  = 1'b1;
        cfg_holdoff_len = 16'd5;
        cfg_err_limit   = 8'd1;
        for (int c = 0; c < 5; c++) begin
            iq_valid      = (c == 0);
            iq_slew_error = (c == 4);
            step;
        end
        iq_slew_error = 1'b0;
        n_tests++;
        if (prot_state !== 2'd2 || pa_blank !== 1'b1) begin
            n_fail++; $display("FAIL auto_trip got st=%0d blank=%b want 2/1",
                               prot_state, pa_blank);
        end
        blank_cnt = (pa_blank === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            step;
            if (pa_blank !== 1'b1) break;
            blank_cnt++;
        end
        n_tests++;
        if (blank_cnt != 6) begin
            n_fail++; $display("FAIL blank_width got %0d want 6", blank_cnt);
        end
        n_tests++;
        if (prot_state !== 2'd1 || err_count !== 8'd0 || trip_count !== 16'd1) begin
            n_fail++; $display("FAIL auto_rearm got st=%0d err=%0d trips=%0d want 1/0/1",
                               prot_state, err_count, trip_count);
        end
    endtask

    task automatic test_clear_coincident;
        cfg_auto_rearm = 1'b0;
        for (int c = 0; c < 5; c++) begin
            iq_valid      = (c == 0);
            iq_slew_error = (c == 4);
            cfg_clear     = (c == 4);
            step;
        end
        iq_slew_error = 1'b0;
        cfg_clear     = 1'b0;
        n_tests++;
        if (prot_state !== 2'd2 || trip_count !== 16'd1) begin
            n_fail++; $display("FAIL clear_vs_trip got st=%0d trips=%0d want 2/1",
                               prot_state, trip_count);
        end
        step;
        n_tests++;
        if (prot_state !== 2'd2) begin
            n_fail++; $display("FAIL clear_ignored got st=%0d want 2", prot_state);
        end
    endtask

    task automatic test_disable_in_holdoff;
        cfg_clear = 1'b1;
        step;
        cfg_clear = 1'b0;
        n_tests++;
        if (prot_state !== 2'd3 || trip_count !== 16'd0) begin
            n_fail++; $display("FAIL to_holdoff got st=%0d trips=%0d want 3/0",
                               prot_state, trip_count);
        end
        cfg_enable = 1'b0;
        step;
        n_tests++;
        if (prot_state !== 2'd0 || pa_blank !== 1'b0) begin
            n_fail++; $display("FAIL disable got st=%0d blank=%b want 0/0", prot_state, pa_blank);
        end
    endtask

    // limit 0 acts as 1; errors without an aligned valid must be ignored
    task automatic test_valid_gating;
        int bad = 0;
        cfg_err_limit = 8'd0;
        cfg_enable    = 1'b1;
        step;
        iq_valid      = 1'b0;
        iq_slew_error = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            if (prot_state !== 2'd1) bad++;
        end
        n_tests++;
        if (bad != 0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL unaligned_err got bad=%0d err=%0d want 0/0", bad, err_count);
        end
        for (int c = 0; c < 5; c++) begin
            iq_valid = (c == 0);
            step;
        end
        iq_slew_error = 1'b0;
        n_tests++;
        if (prot_state !== 2'd2 || err_count !== 8'd1 || trip_count !== 16'd1) begin
            n_fail++; $display("FAIL limit0_trip got st=%0d err=%0d trips=%0d want 2/1/1",
                               prot_state, err_count, trip_count);
        end
    endtask

    task automatic test_async_reset;
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (pa_blank !== 1'b0 || prot_state !== 2'd0 || slew_threshold !== 33'h1_FFFF_FFFF) begin
            n_fail++; $display("FAIL async_reset got blank=%b st=%0d thr=%h want 0/0/1ffffffff",
                               pa_blank, prot_state, slew_threshold);
        end
        step;
        resetn = 1'b1;
        step;
    endtask

    initial begin
        resetn             = 1'b0;
        cfg_enable         = 1'b0;
        cfg_auto_rearm     = 1'b0;
        cfg_clear          = 1'b0;
        cfg_slew_threshold = THR0;
        cfg_err_limit      = 8'd0;
        cfg_window_len     = 16'd0;
        cfg_holdoff_len    = 16'd5;
        iq_valid           = 1'b0;
        iq_slew_error      = 1'b0;
        test_reset;
        test_trip;
        test_manual_clear;
        test_window_rollover;
        test_auto_rearm;
        test_clear_coincident;
        test_disable_in_holdoff;
        test_valid_gating;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
